// File: rtl/eye_test_pkg.sv
// Shared constants, FSM state type and ASCII frame helpers for the eye-test result UART.
package eye_test_pkg;
   localparam logic [7:0] CH_S  = 8'h53;
   localparam logic [7:0] CH_A  = 8'h41;
   localparam logic [7:0] CH_C  = 8'h43;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam int         FRAME_LEN = 8;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} tx_state_t;

   function automatic logic [7:0] hex_ascii(input logic [3:0] v);
      return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
   endfunction

   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [3:0] size,
                                             input logic ast, input logic col);
      logic [7:0] b;
      case (idx)
         3'd0:    b = CH_S;
         3'd1:    b = hex_ascii(size);
         3'd2:    b = CH_A;
         3'd3:    b = 8'h30 + {7'h0, ast};
         3'd4:    b = CH_C;
         3'd5:    b = 8'h30 + {7'h0, col};
         3'd6:    b = CH_CR;
         default: b = CH_LF;
      endcase
      return b;
   endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. o_ready is also high in the last stop-bit cycle so the next
// byte can be accepted there and frames run back to back without an idle gap.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_tx
);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   logic          busy;
   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shift;

   assign o_ready = !busy || (bit_cnt == 4'd9 && baud_cnt == BAUD_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy     <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         o_tx     <= 1'b1;
      end else if (i_valid && o_ready) begin
         busy     <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= {1'b1, i_data};
         o_tx     <= 1'b0;
      end else if (busy) begin
         if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               busy <= 1'b0;
               o_tx <= 1'b1;
            end else begin
               // data bits LSB first, the trailing 1 in shift becomes the stop bit
               bit_cnt <= bit_cnt + 4'd1;
               o_tx    <= shift[0];
               shift   <= {1'b0, shift[8:1]};
            end
         end else begin
            baud_cnt <= baud_cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/result_uart_tx.sv
// Snapshots the eye-test results on an armed request and sends them once as an
// 8-byte ASCII frame over 8N1 UART.
module result_uart_tx
   import eye_test_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       start_to_send,
   input  logic [3:0] o_size,
   input  logic       astigmatism_result,
   input  logic       color_test_result,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_sent
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   tx_state_t  state, nxt;
   logic       armed;
   logic [3:0] snap_size;
   logic       snap_ast, snap_col;
   logic [2:0] idx;
   logic       load, ready, trigger;
   logic [7:0] load_byte;

   assign trigger = (state == IDLE) && armed && start_to_send;

   // The byte hand-over happens in the cycle the serialiser reports ready (or the
   // trigger cycle for byte 0), which keeps the start-bit latency to one cycle.
   always_comb begin
      nxt       = state;
      load      = 1'b0;
      load_byte = CH_S;
      case (state)
         IDLE: if (trigger) begin
            load = 1'b1;
            nxt  = SEND;
         end
         SEND: if (ready) begin
            if (idx == 3'(FRAME_LEN - 1)) begin
               nxt = DONE;
            end else begin
               load      = 1'b1;
               load_byte = frame_byte(idx + 3'd1, snap_size, snap_ast, snap_col);
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         armed     <= 1'b0;
         snap_size <= '0;
         snap_ast  <= 1'b0;
         snap_col  <= 1'b0;
         idx       <= '0;
      end else begin
         state <= nxt;
         if (trigger) begin
            armed     <= 1'b0;
            snap_size <= o_size;
            snap_ast  <= astigmatism_result;
            snap_col  <= color_test_result;
            idx       <= '0;
         end else begin
            if (state == IDLE && !start_to_send) armed <= 1'b1;
            if (state == SEND && load) idx <= idx + 3'd1;
         end
      end
   end

   assign o_busy = (state == SEND) || (state == LOAD);
   assign o_sent = (state == DONE);

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_data  (load_byte),
      .i_valid (load),
      .o_ready (ready),
      .o_tx    (o_tx)
   );
endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at 16 clocks per bit: frame bytes, bit timing, arming and reset.
module tb_result_uart_tx;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] size;
   logic       ast, col;
   logic       o_tx, o_busy, o_sent;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         sent_cnt = 0;

   typedef struct {
      logic [3:0]      size;
      logic            ast;
      logic            col;
      logic [7:0][7:0] exp;
   } vec_t;

   vec_t vecs[6];

   result_uart_tx #(.CLK_HZ(16), .BAUD(1)) dut (
      .i_clk(clk), .i_rst(rst), .start_to_send(start), .o_size(size),
      .astigmatism_result(ast), .color_test_result(col),
      .o_tx(o_tx), .o_busy(o_busy), .o_sent(o_sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (o_sent === 1'b1) sent_cnt <= sent_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic quiet(input int n, input string nm);
      int act = 0;
      for (int i = 0; i < n; i++) begin
         step(1);
         if (o_tx !== 1'b1 || o_busy !== 1'b0) act++;
      end
      chk(nm, act, 0);
   endtask

   // mid=1 changes inputs during byte 2 and pulses start_to_send low/high mid-frame
   task automatic run_frame(input logic [3:0] sz, input logic a, input logic c,
                            input logic [7:0][7:0] exp, input bit mid);
      logic [7:0] b;
      int         s0;
      start = 1'b0; size = sz; ast = a; col = c;
      step(3);
      start = 1'b1;
      step(1);
      chk("latency_busy", o_busy, 1);
      s0 = sent_cnt;
      for (int k = 0; k < 8; k++) begin
         if (mid && k == 2) begin size = 4'd3; ast = 1'b0; end
         if (mid && k == 4) start = 1'b0;
         if (mid && k == 5) start = 1'b1;
         chk($sformatf("start_edge_b%0d", k), o_tx, 0);
         step(8);
         chk($sformatf("start_mid_b%0d", k), o_tx, 0);
         for (int i = 0; i < 8; i++) begin
            step(16);
            b[i] = o_tx;
         end
         step(16);
         chk($sformatf("stop_b%0d", k), o_tx, 1);
         chk($sformatf("byte%0d", k), b, exp[k]);
         step(8);
      end
      chk("sent_at_1280", o_sent, 1);
      chk("busy_drop", o_busy, 0);
      step(1);
      chk("sent_one_cycle", o_sent, 0);
      chk("sent_count", sent_cnt - s0, 1);
   endtask

   initial begin
      int s0;
      vecs[0] = '{4'd7,  1'b1, 1'b0, {8'h0A, 8'h0D, 8'h30, 8'h43, 8'h31, 8'h41, 8'h37, 8'h53}};
      vecs[1] = '{4'd12, 1'b0, 1'b1, {8'h0A, 8'h0D, 8'h31, 8'h43, 8'h30, 8'h41, 8'h43, 8'h53}};
      vecs[2] = '{4'd15, 1'b1, 1'b1, {8'h0A, 8'h0D, 8'h31, 8'h43, 8'h31, 8'h41, 8'h46, 8'h53}};
      vecs[3] = '{4'd0,  1'b0, 1'b0, {8'h0A, 8'h0D, 8'h30, 8'h43, 8'h30, 8'h41, 8'h30, 8'h53}};
      vecs[4] = '{4'd9,  1'b0, 1'b0, {8'h0A, 8'h0D, 8'h30, 8'h43, 8'h30, 8'h41, 8'h39, 8'h53}};
      vecs[5] = '{4'd10, 1'b1, 1'b0, {8'h0A, 8'h0D, 8'h30, 8'h43, 8'h31, 8'h41, 8'h41, 8'h53}};

      rst = 1'b1; start = 1'b1; size = 4'd0; ast = 1'b0; col = 1'b0;
      step(3);
      chk("rst_tx", o_tx, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_sent", o_sent, 0);
      rst = 1'b0;
      quiet(2000, "no_frame_held_after_rst");
      chk("no_sent_held_after_rst", sent_cnt, 0);

      for (int v = 0; v < 6; v++) begin
         run_frame(vecs[v].size, vecs[v].ast, vecs[v].col, vecs[v].exp, 1'b0);
         if (v == 0) begin
            s0 = sent_cnt;
            quiet(5000, "hold_high_single_frame");
            chk("hold_high_sent", sent_cnt - s0, 0);
         end
      end
      run_frame(vecs[0].size, vecs[0].ast, vecs[0].col, vecs[0].exp, 1'b0);

      run_frame(4'd7, 1'b1, 1'b0, vecs[0].exp, 1'b1);
      s0 = sent_cnt;
      quiet(500, "no_requeue_after_toggle");
      chk("no_requeue_sent", sent_cnt - s0, 0);

      // reset during data bit 3 of byte 3 ('0' = 0x30, bit 3 is 0)
      start = 1'b0; size = 4'd7; ast = 1'b0; col = 1'b0;
      step(3);
      start = 1'b1;
      step(1);
      s0 = sent_cnt;
      step(3 * 160 + 4 * 16 + 8);
      chk("pre_rst_low_bit", o_tx, 0);
      rst = 1'b1;
      #1;
      chk("midrst_tx_async", o_tx, 1);
      chk("midrst_busy", o_busy, 0);
      step(1);
      rst = 1'b0;
      quiet(500, "midrst_no_resend");
      chk("midrst_no_sent", sent_cnt - s0, 0);
      run_frame(vecs[0].size, vecs[0].ast, vecs[0].col, vecs[0].exp, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
